// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, requests words over a req/ack handshake,
// presents one registered instruction to the decoder and applies control-flow redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  jump,
    input  logic [25:0] target,
    input  logic [15:0] immediate,
    input  logic [31:0] jr_addr,
    input  logic [31:0] resolve_pc
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_VALID   = 2'b01,
        S_DISCARD = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    logic        redir_s;
    logic        ack_s;
    logic [31:0] redir_tgt_s;

    // Jump-type 11 is not a real redirect and yields the fall-through address.
    function automatic logic [31:0] redirect_target(
        input logic [1:0]  jmp,
        input logic [25:0] tgt,
        input logic [15:0] imm,
        input logic [31:0] jra,
        input logic [31:0] rpc
    );
        logic [31:0] seq;
        seq = rpc + 32'd4;
        case (jmp)
            2'b10:   redirect_target = {seq[31:28], tgt, 2'b00};
            2'b01:   redirect_target = {jra[31:2], 2'b00};
            2'b00:   redirect_target = seq + {{14{imm[15]}}, imm, 2'b00};
            default: redirect_target = seq;
        endcase
    endfunction

    assign redir_s     = redirect && (jump != 2'b11);
    assign ack_s       = imem_ack && req_q;
    assign redir_tgt_s = redirect_target(jump, target, immediate, jr_addr, resolve_pc);

    // Next-state and next-output computation for the fetch controller.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        case (state_q)
            S_FETCH: begin
                if (redir_s) begin
                    pc_d = redir_tgt_s;
                    // An unacked request must finish on its original address.
                    if (req_q && !ack_s) begin
                        state_d = S_DISCARD;
                    end else begin
                        addr_d = redir_tgt_s;
                        req_d  = 1'b1;
                    end
                end else if (ack_s) begin
                    instr_d    = imem_rdata;
                    pc_out_d   = pc_q;
                    pc_plus4_d = pc_q + 32'd4;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    addr_d     = pc_q + 32'd4;
                    req_d      = 1'b0;
                    state_d    = S_VALID;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_VALID: begin
                if (redir_s) begin
                    valid_d = 1'b0;
                    pc_d    = redir_tgt_s;
                    addr_d  = redir_tgt_s;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_VALID;
                end
            end
            S_DISCARD: begin
                pc_d = redir_s ? redir_tgt_s : pc_q;
                if (ack_s) begin
                    addr_d  = pc_d;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d = S_FETCH;
                req_d   = 1'b0;
                valid_d = 1'b0;
                addr_d  = pc_q;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= 32'h0000_0000;
            valid_q    <= 1'b0;
            pc_out_q   <= RESET_PC;
            pc_plus4_q <= RESET_PC + 32'd4;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_plus4_q;

endmodule
